// File: rtl/inst_mem_pkg.sv
// Shared definitions for the instruction-memory loader: NOP encoding,
// loader state encoding and the number of byte lanes per word.
package inst_mem_pkg;

   localparam logic [31:0] NOP   = 32'h0000_0013;
   localparam int unsigned LANES = 4;

   typedef enum logic {
      RUN  = 1'b0,
      LOAD = 1'b1
   } state_t;

endpackage

// File: rtl/byte_packer.sv
// Packs a byte stream little-endian into 32-bit words. The strobe and the
// assembled word are combinational in the cycle the fourth byte is accepted,
// so the word can be written at that same clock edge.
module byte_packer
   import inst_mem_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        i_clr,
   input  logic        i_accept,
   input  logic [7:0]  i_byte,
   output logic        o_word_valid,
   output logic [31:0] o_word
);

   logic [1:0]  r_lane;
   logic [31:0] r_stage;

   // Lane counter and staging register; a clear drops any partial word.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_lane  <= '0;
         r_stage <= '0;
      end else if (i_clr) begin
         r_lane  <= '0;
         r_stage <= '0;
      end else if (i_accept) begin
         r_stage[8*r_lane +: 8] <= i_byte;
         r_lane                 <= r_lane + 2'd1;
      end
   end

   // Staging word merged with the byte being accepted this cycle.
   always_comb begin
      o_word                 = r_stage;
      o_word[8*r_lane +: 8]  = i_byte;
      o_word_valid           = i_accept && (r_lane == 2'(LANES - 1));
   end

endmodule

// File: rtl/inst_mem_loader.sv
// Instruction memory with a combinational fetch port and a byte-stream
// program-load port. While loading, the core is held and fetches see NOPs.
// Optional feature macro: INST_MEM_LOADER_CHECKSUM_EN adds load_checksum_o,
// the modulo-256 sum of the bytes accepted in the current load.
module inst_mem_loader
   import inst_mem_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] inst_mem_addr_i,
   output logic [31:0] inst_mem_data_o,
   output logic        fetch_fault_o,
   input  logic        load_start_i,
   input  logic [15:0] load_len_i,
   input  logic        load_valid_i,
   input  logic [7:0]  load_data_i,
   output logic        load_ready_o,
   output logic        load_done_o,
   output logic        core_hold_o
`ifdef INST_MEM_LOADER_CHECKSUM_EN
   ,
   output logic [7:0]  load_checksum_o
`endif
);

   localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

   state_t      r_state;
   state_t      w_state_next;
   logic [15:0] r_len;
   logic [15:0] r_wptr;
   logic        r_done;
   logic [31:0] r_mem [DEPTH_WORDS];

   logic        w_start;
   logic        w_finish;
   logic        w_ready;
   logic        w_accept;
   logic        w_word_valid;
   logic [31:0] w_word;
   logic [15:0] w_len_clamped;
   logic [31:0] w_off;
   logic [31:0] w_idx;
   logic        w_bad;

   assign w_len_clamped = (32'(load_len_i) > DEPTH_WORDS) ? 16'(DEPTH_WORDS) : load_len_i;

   // Ready is withheld once every word is written, which also keeps a
   // zero-length load from accepting anything in its single LOAD cycle.
   assign w_ready      = (r_state == LOAD) && (r_wptr != r_len);
   assign w_accept     = load_valid_i && w_ready;
   assign load_ready_o = w_ready;
   assign core_hold_o  = (r_state == LOAD);
   assign load_done_o  = r_done;

   byte_packer u_packer (
      .clk          (clk),
      .rst          (rst),
      .i_clr        (w_start),
      .i_accept     (w_accept),
      .i_byte       (load_data_i),
      .o_word_valid (w_word_valid),
      .o_word       (w_word)
   );

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= RUN;
      else     r_state <= w_state_next;
   end

   // Next state: leave LOAD on the edge that writes the last word (or at once
   // for a zero-length load), so the following cycle is the completion cycle.
   always_comb begin
      w_state_next = r_state;
      w_start      = 1'b0;
      w_finish     = 1'b0;
      unique case (r_state)
         RUN: begin
            if (load_start_i) begin
               w_state_next = LOAD;
               w_start      = 1'b1;
            end
         end
         LOAD: begin
            if ((r_wptr == r_len) || (w_word_valid && ((r_wptr + 16'd1) == r_len))) begin
               w_state_next = RUN;
               w_finish     = 1'b1;
            end
         end
         default: w_state_next = RUN;
      endcase
   end

   // Captured length, word pointer and the registered done pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_len  <= '0;
         r_wptr <= '0;
         r_done <= 1'b0;
      end else begin
         r_done <= w_finish;
         if (w_start) begin
            r_len  <= w_len_clamped;
            r_wptr <= '0;
         end else if (w_word_valid) begin
            r_wptr <= r_wptr + 16'd1;
         end
      end
   end

   // Memory write; contents survive reset.
   always_ff @(posedge clk) begin
      if (w_word_valid) r_mem[r_wptr[AW-1:0]] <= w_word;
   end

   assign w_off = inst_mem_addr_i - BASE_ADDR;
   assign w_idx = w_off >> 2;
   assign w_bad = (inst_mem_addr_i[1:0] != 2'b00) ||
                  (inst_mem_addr_i < BASE_ADDR) ||
                  (w_idx >= DEPTH_WORDS);

   // Fetch port: NOP without fault while loading, NOP with fault on a bad address.
   always_comb begin
      inst_mem_data_o = NOP;
      fetch_fault_o   = 1'b0;
      if (r_state == RUN) begin
         if (w_bad) fetch_fault_o = 1'b1;
         else       inst_mem_data_o = r_mem[w_idx[AW-1:0]];
      end
   end

`ifdef INST_MEM_LOADER_CHECKSUM_EN
   logic [7:0] r_csum;

   // Running byte sum of the current load, held after completion.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)           r_csum <= '0;
      else if (w_start)  r_csum <= '0;
      else if (w_accept) r_csum <= r_csum + load_data_i;
   end

   assign load_checksum_o = r_csum;
`endif

endmodule

// File: tb/tb_inst_mem_loader.sv
// Scoreboard bench for inst_mem_loader: expected fetch results are queued as
// load bytes are driven and compared when the words are fetched back.
module tb_inst_mem_loader;
   import inst_mem_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] addr;
   logic [31:0] data_o;
   logic        fault;
   logic        start;
   logic [15:0] len;
   logic        valid;
   logic [7:0]  bdata;
   logic        ready;
   logic        done;
   logic        hold;
`ifdef INST_MEM_LOADER_CHECKSUM_EN
   logic [7:0]  csum;
`endif

   inst_mem_loader #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0000_0000)) dut (
      .clk             (clk),
      .rst             (rst),
      .inst_mem_addr_i (addr),
      .inst_mem_data_o (data_o),
      .fetch_fault_o   (fault),
      .load_start_i    (start),
      .load_len_i      (len),
      .load_valid_i    (valid),
      .load_data_i     (bdata),
      .load_ready_o    (ready),
      .load_done_o     (done),
      .core_hold_o     (hold)
`ifdef INST_MEM_LOADER_CHECKSUM_EN
      ,
      .load_checksum_o (csum)
`endif
   );

   always #5 clk = ~clk;

   int unsigned total = 0;
   int unsigned bad   = 0;

   typedef struct {
      logic [31:0] a;
      logic [31:0] d;
   } exp_t;

   exp_t       sb[$];
   logic [7:0] tx[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Queue the bytes of one word and its expected fetch result.
   task automatic push_word(input logic [31:0] a, input logic [31:0] w);
      exp_t e;
      for (int k = 0; k < 4; k++) tx.push_back(w[8*k +: 8]);
      e.a = a;
      e.d = w;
      sb.push_back(e);
   endtask

   task automatic start_load(input logic [15:0] n);
      @(negedge clk);
      start = 1'b1;
      len   = n;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Send all queued bytes; gap inserts an idle cycle before each byte.
   // Returns at the negedge after the edge that accepted the last byte.
   task automatic send_bytes(input bit gap);
      int unsigned n;
      n = tx.size();
      for (int unsigned i = 0; i < n; i++) begin
         int unsigned wc;
         wc = 0;
         if (gap) begin
            @(negedge clk);
            valid = 1'b0;
         end
         @(negedge clk);
         valid = 1'b1;
         bdata = tx[i];
         #1;
         check("hold_in_load", 32'(hold), 32'd1);
         check("nop_in_load", data_o, NOP);
         check("nofault_in_load", 32'(fault), 32'd0);
         while (!ready && wc < 20) begin
            @(negedge clk);
            #1;
            wc++;
         end
         if (!ready) check("ready_timeout", 32'(ready), 32'd1);
         @(posedge clk);
      end
      @(negedge clk);
      valid = 1'b0;
      tx.delete();
   endtask

   task automatic check_completion(input string tag);
      #1;
      check({tag, "_done"}, 32'(done), 32'd1);
      check({tag, "_ready_low"}, 32'(ready), 32'd0);
      check({tag, "_hold_low"}, 32'(hold), 32'd0);
      @(negedge clk);
      #1;
      check({tag, "_done_once"}, 32'(done), 32'd0);
   endtask

   task automatic drain_scoreboard(input string tag);
      while (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         addr = e.a;
         #1;
         check({tag, "_data"}, data_o, e.d);
         check({tag, "_fault"}, 32'(fault), 32'd0);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst   = 1'b1;
      addr  = 32'h0;
      start = 1'b0;
      len   = '0;
      valid = 1'b0;
      bdata = '0;
      repeat (2) @(negedge clk);
      #1;
      check("rst_hold", 32'(hold), 32'd0);
      check("rst_ready", 32'(ready), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      #1;
      check("fetch0_fault", 32'(fault), 32'd0);
      check("fetch0_hold", 32'(hold), 32'd0);
      check("fetch0_ready", 32'(ready), 32'd0);

      // Back-to-back load of two words.
      addr = 32'h2;
      push_word(32'h0, 32'h0050_0013);
      push_word(32'h4, 32'h0010_0593);
      start_load(16'd2);
      send_bytes(1'b0);
      check_completion("load_b2b");
      drain_scoreboard("load_b2b");

      // Same load with valid toggling.
      addr = 32'h4;
      push_word(32'h0, 32'h0050_0013);
      push_word(32'h4, 32'h0010_0593);
      start_load(16'd2);
      send_bytes(1'b1);
      check_completion("load_gap");
      drain_scoreboard("load_gap");

      // Bad fetch addresses.
      addr = 32'h2;
      #1;
      check("misalign_data", data_o, NOP);
      check("misalign_fault", 32'(fault), 32'd1);
      addr = 32'h1000;
      #1;
      check("range_data", data_o, NOP);
      check("range_fault", 32'(fault), 32'd1);
      addr = 32'hFFFF_FFFC;
      #1;
      check("top_fault", 32'(fault), 32'd1);
      addr = 32'hFFC;
      #1;
      check("last_word_fault", 32'(fault), 32'd0);

      // Zero-length load: one LOAD cycle, no byte accepted.
      start_load(16'd0);
      valid = 1'b1;
      bdata = 8'hEE;
      #1;
      check("len0_hold", 32'(hold), 32'd1);
      check("len0_ready", 32'(ready), 32'd0);
      @(negedge clk);
      valid = 1'b0;
      check_completion("len0");
      addr = 32'h0;
      #1;
      check("len0_mem0", data_o, 32'h0050_0013);

      // Reset after five bytes of a two-word load.
      tx.push_back(8'hAA); tx.push_back(8'hBB); tx.push_back(8'hCC);
      tx.push_back(8'hDD); tx.push_back(8'hEE);
      start_load(16'd2);
      send_bytes(1'b0);
      rst = 1'b1;
      #1;
      check("abort_hold", 32'(hold), 32'd0);
      check("abort_ready", 32'(ready), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         #1;
         check("abort_no_done", 32'(done), 32'd0);
      end
      addr = 32'h0;
      #1;
      check("abort_mem0", data_o, 32'hDDCC_BBAA);
      addr = 32'h4;
      #1;
      check("abort_mem1", data_o, 32'h0010_0593);

`ifdef INST_MEM_LOADER_CHECKSUM_EN
      check("csum_after_rst", 32'(csum), 32'd0);
      push_word(32'h0, 32'h0403_0201);
      push_word(32'h4, 32'h0807_0605);
      start_load(16'd2);
      send_bytes(1'b0);
      #1;
      check("csum_at_done", 32'(csum), 32'h24);
      check_completion("load_csum");
      check("csum_hold", 32'(csum), 32'h24);
      drain_scoreboard("load_csum");
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
